pcgen: RTL and testbench
========================

# pcgen

Next-PC generator for the fetch stage, replacing the single-cycle combinational PC mux with a registered PC unit. It holds the architectural fetch PC and presents it to instruction fetch over a valid/ready handshake. It takes `NUM_REDIRECT` prioritised redirect channels (e.g. execute-stage branch resolution, predecode/predictor) and tags every request with an epoch, so that downstream stages can discard wrong-path responses.

## Interface
Parameters:
- `NUM_REDIRECT`, default 2: number of redirect channels; channel 0 has highest priority.
- `RESET_PC`, default 64'h8000_0000: PC presented after reset.
- `INST_BYTES`, default 4: sequential PC increment.
- `EPOCH_W`, default 2: epoch tag width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset (asserts immediately, releases synchronously to `clk` by the system).
- `redirect_valid` in NUM_REDIRECT: per-channel redirect request.
- `redirect_pc` in 64*NUM_REDIRECT: per-channel target; channel i occupies bits [64*i+63:64*i].
- `fetch_ready` in 1: fetch accepts the current request.
- `fetch_valid` out 1: request valid.
- `fetch_pc` out 64: request PC.
- `fetch_epoch` out EPOCH_W: epoch of the current request.
- `fetch_misalign` out 1: `fetch_pc` is not `INST_BYTES`-aligned; the request still issues.

## Operation
- State:
  - `pc_q` (64);
  - `epoch_q` (EPOCH_W);
  - `valid_q` (1).
- All outputs come straight from registers: `fetch_pc`=`pc_q`, `fetch_epoch`=`epoch_q`, `fetch_valid`=`valid_q`, `fetch_misalign`=`pc_q % INST_BYTES != 0`.
- There is no combinational path from any input to any output.
- Reset (`resetn`=0, asynchronous):
  - `pc_q`=RESET_PC, `epoch_q`=0, `valid_q`=0;
  - outputs: `fetch_valid`=0, `fetch_pc`=RESET_PC, `fetch_epoch`=0, `fetch_misalign`=0 for aligned RESET_PC.
- Two-state control, IDLE (`valid_q`=0) and RUN (`valid_q`=1):
  - IDLE goes to RUN on the first rising edge with `resetn`=1;
  - RUN exits only through reset.
- Redirect arbitration: the winner is the lowest index i with `redirect_valid[i]`=1; all other channels in that cycle are dropped, not queued.
- Next-state priority, evaluated every edge:
  1. Any redirect valid: `pc_q`←winning `redirect_pc`, `epoch_q`←`epoch_q`+1. This applies regardless of `fetch_ready` and also in IDLE, where it overrides RESET_PC.
  2. Otherwise, if `valid_q & fetch_ready`: `pc_q`←`pc_q`+INST_BYTES.
  3. Otherwise: hold.
- Handshake:
  - A request transfers on an edge with `fetch_valid & fetch_ready`.
  - While `fetch_valid`=1 and not accepted, `fetch_pc` and `fetch_epoch` hold stable unless a redirect occurs.
  - A redirect is the only legal way to change an unaccepted request.
- Redirect in the same cycle as an accepted handshake: the accepted request is issued with the old epoch; the next request carries the target and the new epoch.
- Arithmetic:
  - PC add wraps modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC + 4 = 0).
  - Epoch wraps modulo 2^EPOCH_W.
- Misaligned redirect target: accepted as-is, with `fetch_misalign`=1 while presented; sequential increment continues from the unaligned value.

## Timing
- Redirect-to-`fetch_pc` latency: 1 cycle. The target appears the cycle after `redirect_valid` is sampled.
- Sequential throughput: one PC per cycle while `fetch_ready`=1.
- First valid request: the cycle after the first edge with `resetn`=1.
- Reset asserted mid-run: outputs return to reset values immediately, without waiting for a clock edge; a pending redirect is lost.

## Configuration
- `PCGEN_PERF_EN` defined:
  - adds output `perf_redirect_cnt` (32*NUM_REDIRECT): per-channel count of cycles in which that channel won arbitration;
  - adds output `perf_stall_cnt` (32): count of cycles with `fetch_valid & !fetch_ready`;
  - all counters saturate at 32'hFFFF_FFFF and reset to 0.
- `PCGEN_PERF_EN` not defined: these ports and their counters do not exist; all other behaviour is identical.

## Test plan
- Reset, then `fetch_ready`=1 constantly → `fetch_valid` rises 1 cycle after release; PCs are 0x8000_0000, 0x8000_0004, 0x8000_0008, all with epoch 0.
- `fetch_ready`=0 for 3 cycles at PC 0x8000_0010 → PC and epoch stable; with `PCGEN_PERF_EN`, `perf_stall_cnt`=3.
- Same-cycle `redirect_valid`=2'b11 with ch0=0x8000_1000, ch1=0x8000_2000 → next PC 0x8000_1000, epoch 1; ch1 dropped; `perf_redirect_cnt` ch0=1, ch1=0.
- Redirect to 0x9000_0000 on an accepted handshake at 0x8000_0020 → 0x8000_0020 issued with epoch 0; next request 0x9000_0000 with epoch 1. Four further redirects → epoch wraps to 1.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC, then ready → next PC 0x0. Redirect to 0x8000_0002 → `fetch_misalign`=1.
- `resetn` pulsed low mid-stream between edges → outputs become RESET_PC, `fetch_valid`=0, epoch 0 immediately; fetch restarts as in the first scenario.

Source files
------------

// File: rtl/pcgen.sv
// ============================================================================
// Module   : pcgen
// Purpose  : Registered next-PC generator for the fetch stage. Holds the
//            architectural fetch PC, presents it to instruction fetch over a
//            valid/ready handshake, arbitrates prioritised redirect channels
//            (channel 0 highest) and tags every request with an epoch so that
//            downstream stages can discard wrong-path responses.
// Ports    : clk               - clock, rising edge
//            resetn            - asynchronous active-low reset
//            redirect_valid    - per-channel redirect request
//            redirect_pc       - per-channel target, channel i in [64*i +: 64]
//            fetch_ready       - fetch accepts the current request
//            fetch_valid       - request valid
//            fetch_pc          - request PC
//            fetch_epoch       - epoch tag of the current request
//            fetch_misalign    - fetch_pc not INST_BYTES-aligned
//            perf_redirect_cnt - (PCGEN_PERF_EN) per-channel win counters
//            perf_stall_cnt    - (PCGEN_PERF_EN) valid & !ready cycle counter
// Options  : define PCGEN_PERF_EN to add the saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcgen #(
  parameter int          NUM_REDIRECT = 2,
  parameter logic [63:0] RESET_PC     = 64'h8000_0000,
  parameter int          INST_BYTES   = 4,
  parameter int          EPOCH_W      = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REDIRECT-1:0]   redirect_valid,
  input  logic [64*NUM_REDIRECT-1:0] redirect_pc,
  input  logic                      fetch_ready,
  output logic                      fetch_valid,
  output logic [63:0]               fetch_pc,
  output logic [EPOCH_W-1:0]        fetch_epoch,
`ifdef PCGEN_PERF_EN
  output logic [32*NUM_REDIRECT-1:0] perf_redirect_cnt,
  output logic [31:0]               perf_stall_cnt,
`endif
  output logic                      fetch_misalign
);

  localparam logic [63:0] PC_INC = 64'(INST_BYTES);

  // IDLE presents nothing; RUN is left only through reset.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q;
  logic [63:0]          pc_q;
  logic [EPOCH_W-1:0]   epoch_q;

  logic                    redir_any;
  logic [NUM_REDIRECT-1:0] redir_win;
  logic [63:0]             redir_target;

  // Fixed-priority arbitration: scanning from the top down lets the lowest
  // requesting index overwrite any higher one. Losing channels are dropped.
  always_comb begin
    redir_win    = '0;
    redir_target = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      if (redirect_valid[i]) begin
        redir_win    = '0;
        redir_win[i] = 1'b1;
        redir_target = redirect_pc[64*i +: 64];
      end
    end
    redir_any = |redirect_valid;
  end

  // A redirect wins over sequential advance regardless of fetch_ready and
  // even in IDLE; an accepted request in the same cycle already went out
  // with the old epoch, so only the following request sees the target.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      epoch_q <= '0;
    end else begin
      state_q <= RUN;
      if (redir_any) begin
        pc_q    <= redir_target;
        epoch_q <= epoch_q + EPOCH_W'(1);
      end else if ((state_q == RUN) && fetch_ready) begin
        pc_q    <= pc_q + PC_INC;
      end
    end
  end

  assign fetch_valid    = (state_q == RUN);
  assign fetch_pc       = pc_q;
  assign fetch_epoch    = epoch_q;
  assign fetch_misalign = ((pc_q % PC_INC) != 64'd0);

`ifdef PCGEN_PERF_EN
  logic [31:0] stall_cnt_q;

  generate
    for (genvar g = 0; g < NUM_REDIRECT; g++) begin : g_perf_ch
      logic [31:0] win_cnt_q;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          win_cnt_q <= '0;
        end else if (redir_win[g] && (win_cnt_q != 32'hFFFF_FFFF)) begin
          win_cnt_q <= win_cnt_q + 32'd1;
        end
      end

      assign perf_redirect_cnt[32*g +: 32] = win_cnt_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else if (fetch_valid && !fetch_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pcgen.sv
`default_nettype none

module tb_pcgen;

  localparam int          NR  = 2;
  localparam logic [63:0] RST = 64'h8000_0000;

  logic                clk = 1'b0;
  logic                resetn = 1'b1;
  logic [NR-1:0]       redirect_valid = '0;
  logic [64*NR-1:0]    redirect_pc = '0;
  logic                fetch_ready = 1'b0;
  logic                fetch_valid;
  logic [63:0]         fetch_pc;
  logic [1:0]          fetch_epoch;
  logic                fetch_misalign;
`ifdef PCGEN_PERF_EN
  logic [32*NR-1:0]    perf_redirect_cnt;
  logic [31:0]         perf_stall_cnt;
`endif

  pcgen #(
    .NUM_REDIRECT (NR),
    .RESET_PC     (RST),
    .INST_BYTES   (4),
    .EPOCH_W      (2)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_epoch    (fetch_epoch),
`ifdef PCGEN_PERF_EN
    .perf_redirect_cnt (perf_redirect_cnt),
    .perf_stall_cnt    (perf_stall_cnt),
`endif
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic [1:0]  ep;
    logic        mis;
  } exp_t;

  typedef struct {
    logic [1:0]  rv;
    logic [63:0] pc0;
    logic [63:0] pc1;
    logic        rdy;
    exp_t        e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[$];

  function automatic exp_t mke(logic v, logic [63:0] pc, logic [1:0] ep, logic mis);
    exp_t e;
    e.v = v; e.pc = pc; e.ep = ep; e.mis = mis;
    return e;
  endfunction

  task automatic addv(logic [1:0] rv, logic [63:0] pc0, logic [63:0] pc1, logic rdy,
                      logic [63:0] epc, logic [1:0] eep, logic emis);
    vec_t t;
    t.rv = rv; t.pc0 = pc0; t.pc1 = pc1; t.rdy = rdy;
    t.e = mke(1'b1, epc, eep, emis);
    vecs.push_back(t);
  endtask

  task automatic check_field(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(string tag, exp_t e);
    check_field({tag, ".valid"},    64'(fetch_valid),    64'(e.v));
    check_field({tag, ".pc"},       fetch_pc,            e.pc);
    check_field({tag, ".epoch"},    64'(fetch_epoch),    64'(e.ep));
    check_field({tag, ".misalign"}, 64'(fetch_misalign), 64'(e.mis));
  endtask

  task automatic check_perf(string tag, int unsigned stall, int unsigned c0, int unsigned c1);
`ifdef PCGEN_PERF_EN
    check_field({tag, ".stall"}, 64'(perf_stall_cnt),           64'(stall));
    check_field({tag, ".ch0"},   64'(perf_redirect_cnt[31:0]),  64'(c0));
    check_field({tag, ".ch1"},   64'(perf_redirect_cnt[63:32]), 64'(c1));
`else
    if (tag.len() < 0) $display("%0d %0d %0d", stall, c0, c1);
`endif
  endtask

  // Drive inputs now (caller is away from the edge), queue the expected
  // registered result, and compare it once the next rising edge has passed.
  task automatic step(string tag, logic [1:0] rv, logic [63:0] pc0, logic [63:0] pc1,
                      logic rdy, exp_t e);
    exp_t x;
    redirect_valid = rv;
    redirect_pc    = {pc1, pc0};
    fetch_ready    = rdy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty got 0 entries expected 1", tag);
    end else begin
      x = sb.pop_front();
      check_out(tag, x);
    end
  endtask

  initial begin
    // Sequential start, 3-cycle stall at 0x10.
    addv(2'b00, 64'h0, 64'h0, 1'b1, 64'h8000_0000, 2'd0, 1'b0);
    addv(2'b00, 64'h0, 64'h0, 1'b1, 64'h8000_0004, 2'd0, 1'b0);
    addv(2'b00, 64'h0, 64'h0, 1'b1, 64'h8000_0008, 2'd0, 1'b0);
    addv(2'b00, 64'h0, 64'h0, 1'b1, 64'h8000_000C, 2'd0, 1'b0);
    addv(2'b00, 64'h0, 64'h0, 1'b1, 64'h8000_0010, 2'd0, 1'b0);
    addv(2'b00, 64'h0, 64'h0, 1'b0, 64'h8000_0010, 2'd0, 1'b0);
    addv(2'b00, 64'h0, 64'h0, 1'b0, 64'h8000_0010, 2'd0, 1'b0);
    addv(2'b00, 64'h0, 64'h0, 1'b0, 64'h8000_0010, 2'd0, 1'b0);
    addv(2'b00, 64'h0, 64'h0, 1'b1, 64'h8000_0014, 2'd0, 1'b0);
    addv(2'b00, 64'h0, 64'h0, 1'b1, 64'h8000_0018, 2'd0, 1'b0);
    addv(2'b00, 64'h0, 64'h0, 1'b1, 64'h8000_001C, 2'd0, 1'b0);
    addv(2'b00, 64'h0, 64'h0, 1'b1, 64'h8000_0020, 2'd0, 1'b0);
    // Redirect on accepted handshake at 0x20, then four more redirects.
    addv(2'b01, 64'h9000_0000, 64'h0, 1'b1, 64'h9000_0000, 2'd1, 1'b0);
    addv(2'b11, 64'h8000_1000, 64'h8000_2000, 1'b0, 64'h8000_1000, 2'd2, 1'b0);
    addv(2'b10, 64'h0, 64'h8000_3000, 1'b1, 64'h8000_3000, 2'd3, 1'b0);
    addv(2'b11, 64'h8000_4000, 64'h8000_5000, 1'b1, 64'h8000_4000, 2'd0, 1'b0);
    addv(2'b01, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 2'd1, 1'b0);
    // 64-bit wrap, then misaligned target.
    addv(2'b00, 64'h0, 64'h0, 1'b1, 64'h0, 2'd1, 1'b0);
    addv(2'b00, 64'h0, 64'h0, 1'b1, 64'h4, 2'd1, 1'b0);
    addv(2'b10, 64'h0, 64'h8000_0002, 1'b0, 64'h8000_0002, 2'd2, 1'b1);
    addv(2'b00, 64'h0, 64'h0, 1'b1, 64'h8000_0006, 2'd2, 1'b1);
    addv(2'b00, 64'h0, 64'h0, 1'b1, 64'h8000_000A, 2'd2, 1'b1);

    #1 resetn = 1'b0;
    #1;
    check_out("reset", mke(1'b0, RST, 2'd0, 1'b0));
    check_perf("reset_perf", 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 8) check_perf("stall3", 3, 0, 0);
      step($sformatf("vec%0d", i), vecs[i].rv, vecs[i].pc0, vecs[i].pc1, vecs[i].rdy, vecs[i].e);
    end
    check_perf("table_perf", 6, 4, 2);

    // Asynchronous reset mid-cycle: outputs must drop before any edge.
    #3 resetn = 1'b0;
    #1;
    check_out("async_reset", mke(1'b0, RST, 2'd0, 1'b0));
    check_perf("async_reset_perf", 0, 0, 0);
    // A redirect during reset is lost.
    redirect_valid = 2'b01;
    redirect_pc    = {64'h0, 64'h1234};
    @(posedge clk); #1;
    check_out("reset_hold", mke(1'b0, RST, 2'd0, 1'b0));
    redirect_valid = 2'b00;
    resetn = 1'b1;
    step("restart0", 2'b00, 64'h0, 64'h0, 1'b1, mke(1'b1, 64'h8000_0000, 2'd0, 1'b0));
    step("restart1", 2'b00, 64'h0, 64'h0, 1'b1, mke(1'b1, 64'h8000_0004, 2'd0, 1'b0));
    step("restart2", 2'b00, 64'h0, 64'h0, 1'b1, mke(1'b1, 64'h8000_0008, 2'd0, 1'b0));

    // Redirect on the very first edge out of reset overrides RESET_PC.
    #3 resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    step("idle_redir", 2'b10, 64'h0, 64'hA000_0000, 1'b1, mke(1'b1, 64'hA000_0000, 2'd1, 1'b0));
    step("idle_next",  2'b00, 64'h0, 64'h0,         1'b1, mke(1'b1, 64'hA000_0004, 2'd1, 1'b0));
    check_perf("idle_perf", 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
